// File: rtl/matrix_pair_packer_if.sv
// Stream-in / pair-out handshake bundle for matrix_pair_packer.
// The slave modport is the packer side; the master modport is the producer/consumer side.
interface matrix_pair_packer_if #(
  parameter int ELEM_W = 16
);
  logic [ELEM_W-1:0]    s_data;
  logic                 s_valid;
  logic                 s_last;
  logic                 s_ready;
  logic [18*ELEM_W-1:0] ab;
  logic                 ab_valid;
  logic                 ab_ready;

  modport master (
    output s_data,
    output s_valid,
    output s_last,
    output ab_ready,
    input  s_ready,
    input  ab,
    input  ab_valid
  );

  modport slave (
    input  s_data,
    input  s_valid,
    input  s_last,
    input  ab_ready,
    output s_ready,
    output ab,
    output ab_valid
  );
endinterface

// File: rtl/matrix_pair_packer.sv
// Collects 18 serial elements (3x3 A then 3x3 B, row-major) into one packed {A, B} word.
// Element 0 lands at the MSBs and element 17 at the LSBs; the word is held until consumed.
module matrix_pair_packer #(
  parameter int ELEM_W = 16
) (
  input  logic                     system1000,
  input  logic                     system1000_rstn,
  matrix_pair_packer_if.slave      bus,
  input  logic                     flush,
  output logic                     frame_err,
  output logic [4:0]               fill_cnt
);

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  localparam logic [4:0] LAST_IDX = 5'd17;

  state_e               state_q, state_d;
  logic [4:0]           fill_cnt_q, fill_cnt_d;
  logic [18*ELEM_W-1:0] ab_q, ab_d;
  logic                 s_ready_q, s_ready_d;
  logic                 ab_valid_q, ab_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic [4:0]           slot_s;
  logic                 elem_xfer_s;
  logic                 out_xfer_s;

  // Next-state decode; flush overrides every other event in the same cycle.
  always_comb begin
    state_d     = state_q;
    fill_cnt_d  = fill_cnt_q;
    ab_d        = ab_q;
    s_ready_d   = s_ready_q;
    ab_valid_d  = ab_valid_q;
    frame_err_d = 1'b0;
    slot_s      = LAST_IDX - fill_cnt_q;
    elem_xfer_s = s_ready_q & bus.s_valid;
    out_xfer_s  = ab_valid_q & bus.ab_ready;

    if (flush) begin
      state_d    = ST_FILL;
      fill_cnt_d = 5'd0;
      s_ready_d  = 1'b1;
      ab_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_FILL: begin
          s_ready_d  = 1'b1;
          ab_valid_d = 1'b0;
          if (elem_xfer_s) begin
            if (fill_cnt_q == LAST_IDX) begin
              if (bus.s_last) begin
                ab_d[slot_s*ELEM_W +: ELEM_W] = bus.s_data;
                fill_cnt_d = 5'd0;
                state_d    = ST_HOLD;
                s_ready_d  = 1'b0;
                ab_valid_d = 1'b1;
              end else begin
                fill_cnt_d  = 5'd0;
                frame_err_d = 1'b1;
              end
            end else if (fill_cnt_q < LAST_IDX) begin
              if (bus.s_last) begin
                fill_cnt_d  = 5'd0;
                frame_err_d = 1'b1;
              end else begin
                ab_d[slot_s*ELEM_W +: ELEM_W] = bus.s_data;
                fill_cnt_d = fill_cnt_q + 5'd1;
              end
            end else begin
              // Counter beyond the frame length cannot occur legally; recover as a framing error.
              fill_cnt_d  = 5'd0;
              frame_err_d = 1'b1;
            end
          end else begin
            fill_cnt_d = fill_cnt_q;
          end
        end
        ST_HOLD: begin
          if (out_xfer_s) begin
            state_d    = ST_FILL;
            s_ready_d  = 1'b1;
            ab_valid_d = 1'b0;
          end else begin
            s_ready_d  = 1'b0;
            ab_valid_d = 1'b1;
          end
        end
        default: begin
          state_d    = ST_FILL;
          fill_cnt_d = 5'd0;
          s_ready_d  = 1'b1;
          ab_valid_d = 1'b0;
        end
      endcase
    end
  end

  // State and registered outputs; reset clears the packed word as well.
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      state_q     <= ST_FILL;
      fill_cnt_q  <= 5'd0;
      ab_q        <= '0;
      s_ready_q   <= 1'b0;
      ab_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_cnt_q  <= fill_cnt_d;
      ab_q        <= ab_d;
      s_ready_q   <= s_ready_d;
      ab_valid_q  <= ab_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.s_ready  = s_ready_q;
  assign bus.ab       = ab_q;
  assign bus.ab_valid = ab_valid_q;
  assign frame_err    = frame_err_q;
  assign fill_cnt     = fill_cnt_q;

endmodule

// File: doc/matrix_pair_packer.md
MATRIX_PAIR_PACKER -- requirements
Module: matrix_pair_packer

Interface
REQ-001 The block SHALL have parameter ELEM_W, default 16, giving the signed element width (two's complement, passed through unmodified).
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset: system1000 clock, system1000_rstn reset.
REQ-003 system1000  input  1  rising-edge clock for all state.
REQ-004 system1000_rstn  input  1  asynchronous active-low reset.
REQ-005 s_data  input  ELEM_W  serial element, A row-major then B row-major.
REQ-006 s_valid  input  1  s_data valid.
REQ-007 s_last  input  1  marks the final (18th) element of a frame.
REQ-008 s_ready  output  1  block accepts an element this cycle.
REQ-009 flush  input  1  synchronous abort; discards the partial or held frame.
REQ-010 ab  output  18*ELEM_W  packed pair {A, B}, A in the upper 9*ELEM_W bits.
REQ-011 ab_valid  output  1  ab holds a complete frame.
REQ-012 ab_ready  input  1  downstream consumes ab.
REQ-013 frame_err  output  1  one-cycle pulse on a framing error.
REQ-014 fill_cnt  output  5  elements accepted in the current frame, 0..17.

Function
REQ-015 An element transfer SHALL occur on a rising edge when s_valid=1 and s_ready=1; an output transfer SHALL occur when ab_valid=1 and ab_ready=1.
REQ-016 The FSM SHALL have two states: FILL (s_ready=1, ab_valid=0) and HOLD (s_ready=0, ab_valid=1).
REQ-017 Each accepted element with index k=fill_cnt SHALL be written to ab[(18-k)*ELEM_W-1 -: ELEM_W], so element 0 (A[0][0]) sits at the MSBs and element 17 (B[2][2]) at the LSBs.
REQ-018 The A row r SHALL occupy a contiguous 3*ELEM_W slice, row 0 uppermost; the same SHALL hold for B.
REQ-019 In FILL, accepting an element with k<17 and s_last=0 SHALL increment fill_cnt.
REQ-020 In FILL, accepting k=17 with s_last=1 SHALL write the element, set fill_cnt to 0 and enter HOLD on the same edge, giving ab_valid=1 on the next cycle (1-cycle latency from the last element).
REQ-021 Accepting k<17 with s_last=1 SHALL pulse frame_err, discard the frame and set fill_cnt to 0, remaining in FILL with ab_valid=0.
REQ-022 Accepting k=17 with s_last=0 SHALL pulse frame_err, discard the frame and set fill_cnt to 0, remaining in FILL with ab_valid=0.
REQ-023 In HOLD, ab SHALL remain stable and s_ready SHALL be 0 until the output transfer; s_valid is ignored.
REQ-024 An output transfer SHALL return the FSM to FILL with s_ready=1 on the next cycle.
REQ-025 No bypass SHALL exist: minimum frame period is 19 cycles.
REQ-026 ab contents in FILL SHALL be don't-care for consumers.
REQ-027 Bits of ab not yet rewritten SHALL retain stale values; no clearing between frames.
REQ-028 flush=1 SHALL take priority over every event.
REQ-029 On flush, the block SHALL go to FILL, set fill_cnt=0 and ab_valid=0 next cycle, and SHALL suppress frame_err and any same-cycle element or output transfer.
REQ-030 frame_err SHALL be registered, high for exactly one cycle per error.
REQ-031 s_ready SHALL be a registered output.

Reset
REQ-032 While system1000_rstn=0, outputs SHALL be: s_ready=0, ab_valid=0, frame_err=0, fill_cnt=0, ab=0, state FILL.
REQ-033 s_ready SHALL rise on the first rising edge after reset deassertion.
REQ-034 Reset asserted mid-frame or in HOLD SHALL discard all contents immediately (asynchronously).

Verification
REQ-035 Reset release, then 18 elements 0x0001..0x0012 back-to-back with s_last on the 18th, ab_ready=0 -> ab_valid=1 one cycle later; ab[287:272]=0x0001, ab[15:0]=0x0012; s_ready=0 and ab stable for 10 cycles.
REQ-036 From REQ-035, assert ab_ready for one cycle -> ab_valid=0 and s_ready=1 next cycle; a second frame with s_valid toggling every other cycle -> correct ab after 36 cycles.
REQ-037 s_last on element index 5 -> frame_err single-cycle pulse, fill_cnt=0, no ab_valid; the following well-formed frame packs correctly.
REQ-038 18 elements with s_last=0 throughout -> frame_err pulse on the 18th, ab_valid stays 0.
REQ-039 flush at fill_cnt=9, and separately flush in HOLD together with ab_ready=1 -> fill_cnt=0, ab_valid=0, no frame_err, no output transfer counted.
REQ-040 Assert system1000_rstn=0 asynchronously in HOLD -> ab_valid, s_ready, ab and fill_cnt go to 0 immediately, without waiting for a clock edge.
